// File: rtl/inst_mem_sync.sv
// -----------------------------------------------------------------------------
// inst_mem_sync
// Synchronous instruction memory that sits between the PC register and the
// IF/ID register. Fetches are registered with one cycle of latency and hold
// under pipeline stall. A streaming load port, sequenced by an IDLE/LOAD FSM,
// writes program words at run time. Fetch and load are mutually exclusive by
// state, so reads and writes never collide.
//
// Optional feature (define INST_MEM_PARITY_EN):
//   A per-word even-parity bit is stored on write. load_par_inv_i inverts it
//   for error injection, and rom_par_err_o flags a valid in-range fetch whose
//   stored parity does not match.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rom_ce_i          fetch chip enable
//   rom_stall_i       hold fetch outputs
//   rom_addr_i        fetch byte address
//   rom_data_o        fetched instruction (registered)
//   rom_valid_o       rom_data_o is a real fetch result
//   rom_misalign_o    sampled fetch address had addr[1:0] != 0
//   load_start_i      begin a load burst (sampled in IDLE only)
//   load_base_i       burst start byte address, bits [1:0] ignored
//   load_len_i        burst length in words
//   load_valid_i      load_data_i is valid
//   load_data_i       word to write
//   load_par_inv_i    (parity build) invert stored parity on write
//   rom_par_err_o     (parity build) parity mismatch on fetched word
//   load_ready_o      accepting load words
//   load_busy_o       FSM in LOAD
//   load_done_o       one-cycle pulse at burst completion
// -----------------------------------------------------------------------------
module inst_mem_sync #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH_LOG2 = 10,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rom_ce_i,
    input  logic                  rom_stall_i,
    input  logic [ADDR_WIDTH-1:0] rom_addr_i,
    output logic [DATA_WIDTH-1:0] rom_data_o,
    output logic                  rom_valid_o,
    output logic                  rom_misalign_o,
    input  logic                  load_start_i,
    input  logic [ADDR_WIDTH-1:0] load_base_i,
    input  logic [DEPTH_LOG2:0]   load_len_i,
    input  logic                  load_valid_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
`ifdef INST_MEM_PARITY_EN
    input  logic                  load_par_inv_i,
    output logic                  rom_par_err_o,
`endif
    output logic                  load_ready_o,
    output logic                  load_busy_o,
    output logic                  load_done_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LEN_W = DEPTH_LOG2 + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic                    mem_we_c;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   fetch_idx_c;
    logic                    fetch_oor_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;

    logic [DATA_WIDTH-1:0]   data_d;
    logic                    valid_d;
    logic                    misalign_d;
    logic                    ready_d;
    logic                    busy_d;
    logic                    done_d;

    // Only the word-index bits of the load base are meaningful.
    logic                    unused_base;
    assign unused_base = ^load_base_i;

    assign fetch_idx_c = rom_addr_i[DEPTH_LOG2+1:2];
    assign fetch_oor_c = (rom_addr_i >> (DEPTH_LOG2 + 2)) != '0;
    assign rd_word_c   = mem[fetch_idx_c];

`ifdef INST_MEM_PARITY_EN
    logic mem_par [DEPTH];
    logic par_err_d;
    logic rd_par_bad_c;

    assign rd_par_bad_c = (^rd_word_c) != mem_par[fetch_idx_c];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic: burst setup, word pointer and remaining count
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        mem_we_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_start_i && (load_len_i != '0)) begin
                    state_d = S_LOAD;
                    ptr_d   = load_base_i[DEPTH_LOG2+1:2];
                    rem_d   = load_len_i;
                end
            end
            S_LOAD: begin
                if (load_valid_i) begin
                    mem_we_c = 1'b1;
                    ptr_d    = ptr_q + DEPTH_LOG2'(1);
                    rem_d    = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered fetch and load outputs
    always_comb begin
        data_d     = rom_data_o;
        valid_d    = rom_valid_o;
        misalign_d = rom_misalign_o;
`ifdef INST_MEM_PARITY_EN
        par_err_d  = rom_par_err_o;
`endif
        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d == S_LOAD);
        done_d  = ((state_q == S_IDLE) && load_start_i && (load_len_i == '0)) ||
                  ((state_q == S_LOAD) && load_valid_i && (rem_q == LEN_W'(1)));

        if (state_q == S_LOAD) begin
            // Loading overrides stall: nothing valid is fetched
            data_d     = NOP_WORD;
            valid_d    = 1'b0;
            misalign_d = 1'b0;
`ifdef INST_MEM_PARITY_EN
            par_err_d  = 1'b0;
`endif
        end else if (rom_stall_i) begin
            // hold
        end else if (!rom_ce_i) begin
            data_d     = NOP_WORD;
            valid_d    = 1'b0;
            misalign_d = 1'b0;
`ifdef INST_MEM_PARITY_EN
            par_err_d  = 1'b0;
`endif
        end else begin
            // Misaligned addresses still return the word at the truncated index
            valid_d    = 1'b1;
            misalign_d = |rom_addr_i[1:0];
            data_d     = fetch_oor_c ? NOP_WORD : rd_word_c;
`ifdef INST_MEM_PARITY_EN
            par_err_d  = !fetch_oor_c && rd_par_bad_c;
`endif
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_data_o     <= NOP_WORD;
            rom_valid_o    <= 1'b0;
            rom_misalign_o <= 1'b0;
            load_ready_o   <= 1'b0;
            load_busy_o    <= 1'b0;
            load_done_o    <= 1'b0;
`ifdef INST_MEM_PARITY_EN
            rom_par_err_o  <= 1'b0;
`endif
        end else begin
            rom_data_o     <= data_d;
            rom_valid_o    <= valid_d;
            rom_misalign_o <= misalign_d;
            load_ready_o   <= ready_d;
            load_busy_o    <= busy_d;
            load_done_o    <= done_d;
`ifdef INST_MEM_PARITY_EN
            rom_par_err_o  <= par_err_d;
`endif
        end
    end

    // Word array; contents survive reset, writes are suppressed during reset
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_c) begin
            mem[ptr_q] <= load_data_i;
        end
    end

`ifdef INST_MEM_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_c) begin
            mem_par[ptr_q] <= (^load_data_i) ^ load_par_inv_i;
        end
    end
`endif

endmodule

// File: tb/tb_inst_mem_sync.sv
module tb_inst_mem_sync;

    localparam int          DL    = 10;
    localparam int          DEPTH = 1 << DL;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        rom_ce_i;
    logic        rom_stall_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        rom_valid_o;
    logic        rom_misalign_o;
    logic        load_start_i;
    logic [31:0] load_base_i;
    logic [10:0] load_len_i;
    logic        load_valid_i;
    logic [31:0] load_data_i;
    logic        load_ready_o;
    logic        load_busy_o;
    logic        load_done_o;
`ifdef INST_MEM_PARITY_EN
    logic        load_par_inv_i;
    logic        rom_par_err_o;
`endif

    inst_mem_sync dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_ce_i       (rom_ce_i),
        .rom_stall_i    (rom_stall_i),
        .rom_addr_i     (rom_addr_i),
        .rom_data_o     (rom_data_o),
        .rom_valid_o    (rom_valid_o),
        .rom_misalign_o (rom_misalign_o),
        .load_start_i   (load_start_i),
        .load_base_i    (load_base_i),
        .load_len_i     (load_len_i),
        .load_valid_i   (load_valid_i),
        .load_data_i    (load_data_i),
`ifdef INST_MEM_PARITY_EN
        .load_par_inv_i (load_par_inv_i),
        .rom_par_err_o  (rom_par_err_o),
`endif
        .load_ready_o   (load_ready_o),
        .load_busy_o    (load_busy_o),
        .load_done_o    (load_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, want);
        end
    endtask

    // Reference model: memory as a plain array, burst as a pointer/count pair
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
`ifdef INST_MEM_PARITY_EN
    bit          m_bad   [DEPTH];
    bit          exp_par;
`endif
    bit          m_init = 1'b0;
    bit          m_loading;
    int          m_ptr, m_rem;
    logic [31:0] exp_data;
    bit          exp_known, exp_valid, exp_mis, exp_done, exp_busy;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init    = 1'b1;
            m_loading = 1'b0;
            exp_data  = NOP;
            exp_known = 1'b1;
            exp_valid = 1'b0;
            exp_mis   = 1'b0;
            exp_done  = 1'b0;
            exp_busy  = 1'b0;
`ifdef INST_MEM_PARITY_EN
            exp_par   = 1'b0;
`endif
        end else begin
            exp_done = 1'b0;
            if (m_loading) begin
                exp_data  = NOP;
                exp_known = 1'b1;
                exp_valid = 1'b0;
                exp_mis   = 1'b0;
`ifdef INST_MEM_PARITY_EN
                exp_par   = 1'b0;
`endif
                if (load_valid_i) begin
                    m_mem[m_ptr]   = load_data_i;
                    m_known[m_ptr] = 1'b1;
`ifdef INST_MEM_PARITY_EN
                    m_bad[m_ptr]   = load_par_inv_i;
`endif
                    m_ptr = (m_ptr + 1) % DEPTH;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_loading = 1'b0;
                        exp_done  = 1'b1;
                    end
                end
            end else begin
                if (!rom_stall_i) begin
                    if (!rom_ce_i) begin
                        exp_data  = NOP;
                        exp_known = 1'b1;
                        exp_valid = 1'b0;
                        exp_mis   = 1'b0;
`ifdef INST_MEM_PARITY_EN
                        exp_par   = 1'b0;
`endif
                    end else begin
                        int idx;
                        bit oor;
                        idx       = int'((rom_addr_i / 32'd4) % 32'(DEPTH));
                        oor       = rom_addr_i >= 32'(DEPTH * 4);
                        exp_valid = 1'b1;
                        exp_mis   = (rom_addr_i % 32'd4) != 32'd0;
                        exp_data  = oor ? NOP : m_mem[idx];
                        exp_known = oor || m_known[idx];
`ifdef INST_MEM_PARITY_EN
                        exp_par   = !oor && m_bad[idx];
`endif
                    end
                end
                if (load_start_i) begin
                    if (load_len_i == 11'd0) begin
                        exp_done = 1'b1;
                    end else begin
                        m_loading = 1'b1;
                        m_ptr     = int'((load_base_i / 32'd4) % 32'(DEPTH));
                        m_rem     = int'(load_len_i);
                    end
                end
            end
            exp_busy = m_loading;
        end
    end

    // Compare DUT against the model on every cycle after the first reset
    always @(negedge clk) begin
        if (m_init) begin
            check("valid",    32'(rom_valid_o),    32'(exp_valid));
            check("misalign", 32'(rom_misalign_o), 32'(exp_mis));
            check("busy",     32'(load_busy_o),    32'(exp_busy));
            check("ready",    32'(load_ready_o),   32'(exp_busy));
            check("done",     32'(load_done_o),    32'(exp_done));
            if (exp_known) check("data", rom_data_o, exp_data);
`ifdef INST_MEM_PARITY_EN
            check("par_err", 32'(rom_par_err_o), 32'(exp_par));
`endif
        end
    end

    always @(posedge clk) begin
        if (rst_n && load_done_o) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_load(input logic [31:0] base, input int len);
        load_start_i = 1'b1;
        load_base_i  = base;
        load_len_i   = 11'(len);
        tick();
        load_start_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input bit inv);
        load_valid_i = 1'b1;
        load_data_i  = d;
`ifdef INST_MEM_PARITY_EN
        load_par_inv_i = inv;
`else
        if (inv) load_data_i = d;
`endif
        tick();
        load_valid_i = 1'b0;
`ifdef INST_MEM_PARITY_EN
        load_par_inv_i = 1'b0;
`endif
    endtask

    task automatic fetch(input logic [31:0] a);
        rom_ce_i   = 1'b1;
        rom_addr_i = a;
        tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        rom_ce_i     = 1'b1;
        rom_stall_i  = 1'b0;
        rom_addr_i   = 32'h0;
        load_start_i = 1'b0;
        load_base_i  = 32'h0;
        load_len_i   = 11'd0;
        load_valid_i = 1'b0;
        load_data_i  = 32'h0;
`ifdef INST_MEM_PARITY_EN
        load_par_inv_i = 1'b0;
`endif
        repeat (2) tick();
        check("reset_valid", 32'(rom_valid_o), 32'd0);
        check("reset_data",  rom_data_o, NOP);
        rst_n = 1'b1;
        tick();
        check("post_reset_valid", 32'(rom_valid_o), 32'd1);

        // Three-word burst with a gap cycle
        start_load(32'h0, 3);
        push_word(32'h3401_8000, 1'b0);
        tick();
        push_word(32'h0001_0c00, 1'b0);
        check("no_early_done", 32'(done_cnt), 32'd0);
        push_word(32'h3421_0010, 1'b0);
        check("done_pulse", 32'(load_done_o), 32'd1);
        check("busy_drop",  32'(load_busy_o), 32'd0);
        fetch(32'h0);
        check("done_once", 32'(done_cnt), 32'd1);
        check("fetch0", rom_data_o, 32'h3401_8000);
        fetch(32'h4);
        check("fetch4", rom_data_o, 32'h0001_0c00);
        fetch(32'h8);
        check("fetch8", rom_data_o, 32'h3421_0010);

        // Stall holds while the address moves
        fetch(32'h4);
        rom_stall_i = 1'b1;
        rom_addr_i  = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", rom_data_o, 32'h0001_0c00);
        end
        rom_stall_i = 1'b0;

        fetch(32'h6);
        check("misalign_flag", 32'(rom_misalign_o), 32'd1);
        check("misalign_data", rom_data_o, 32'h0001_0c00);
        fetch(32'h1000);
        check("oor_data",  rom_data_o, NOP);
        check("oor_valid", 32'(rom_valid_o), 32'd1);

        // Wrapping burst
        start_load(32'hFFC, 2);
        push_word(32'hAAAA_0001, 1'b0);
        push_word(32'hBBBB_0002, 1'b0);
        fetch(32'hFFC);
        check("wrap_hi", rom_data_o, 32'hAAAA_0001);
        fetch(32'h0);
        check("wrap_lo", rom_data_o, 32'hBBBB_0002);

        // Reset in the middle of a burst
        start_load(32'h20, 4);
        push_word(32'hCCCC_0003, 1'b0);
        push_word(32'hDDDD_0004, 1'b0);
        rst_n = 1'b0;
        tick();
        check("midrst_busy", 32'(load_busy_o), 32'd0);
        check("midrst_done", 32'(load_done_o), 32'd0);
        rst_n = 1'b1;
        fetch(32'h20);
        check("kept0", rom_data_o, 32'hCCCC_0003);
        fetch(32'h24);
        check("kept1", rom_data_o, 32'hDDDD_0004);
        check("midrst_no_pulse", 32'(done_cnt), 32'd2);

        // Zero-length burst completes immediately
        start_load(32'h100, 0);
        check("len0_done", 32'(load_done_o), 32'd1);
        check("len0_busy", 32'(load_busy_o), 32'd0);

`ifdef INST_MEM_PARITY_EN
        start_load(32'h10, 1);
        push_word(32'h1234_5678, 1'b1);
        fetch(32'h10);
        check("par_inj", 32'(rom_par_err_o), 32'd1);
        fetch(32'h0);
        check("par_clean", 32'(rom_par_err_o), 32'd0);
`endif

        // Fill the whole array, with gaps and ignored restarts
        start_load(32'h0, DEPTH);
        begin
            int n;
            n = 0;
            while (n < DEPTH) begin
                load_valid_i = ($urandom_range(0, 3) != 0);
                load_data_i  = $urandom;
                load_start_i = ($urandom_range(0, 15) == 0);
                load_len_i   = 11'($urandom_range(0, 8));
                if (load_valid_i) n++;
                tick();
            end
            load_valid_i = 1'b0;
            load_start_i = 1'b0;
        end

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n       = ($urandom_range(0, 499) != 0);
            rom_ce_i    = ($urandom_range(0, 7) != 0);
            rom_stall_i = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 9))
                0:       rom_addr_i = $urandom;
                1:       rom_addr_i = 32'h1000 + 32'($urandom_range(0, 63));
                default: rom_addr_i = (32'($urandom_range(0, DEPTH - 1)) << 2) |
                                      (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            endcase
            load_start_i = ($urandom_range(0, 39) == 0);
            load_base_i  = $urandom;
            load_len_i   = 11'($urandom_range(0, 12));
            load_valid_i = ($urandom_range(0, 2) != 0);
            load_data_i  = $urandom;
`ifdef INST_MEM_PARITY_EN
            load_par_inv_i = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end
        rst_n        = 1'b1;
        load_start_i = 1'b0;
        load_valid_i = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
- Parametrised, synchronous successor to the pipeline's combinational instruction ROM.
- Serves IF-stage fetches with one-cycle registered latency and honours pipeline stall.
- Adds a streaming program-load port driven by an FSM, so test programs can be written at run time instead of hard-coded.
- Sits between PC register and IF/ID register.

Parameters:
- ADDR_WIDTH, 32, width of byte address buses.
- DATA_WIDTH, 32, instruction word width.
- DEPTH_LOG2, 10, log2 of word count (default 1024 words = 4 KiB).
- NOP_WORD, 32'h0000_0000, word returned when disabled, out of range or loading.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rom_ce_i  in  1  fetch chip enable.
- rom_stall_i  in  1  hold fetch outputs.
- rom_addr_i  in  ADDR_WIDTH  fetch byte address.
- rom_data_o  out  DATA_WIDTH  fetched instruction (registered).
- rom_valid_o  out  1  rom_data_o is a real fetch result.
- rom_misalign_o  out  1  sampled address had addr[1:0]!=0.
- load_start_i  in  1  begin load burst (sampled in IDLE only).
- load_base_i  in  ADDR_WIDTH  burst start byte address; bits [1:0] ignored.
- load_len_i  in  DEPTH_LOG2+1  burst length in words.
- load_valid_i  in  1  load_data_i is valid.
- load_data_i  in  DATA_WIDTH  word to write.
- load_ready_o  out  1  accepting load words.
- load_busy_o  out  1  FSM in LOAD.
- load_done_o  out  1  one-cycle pulse at burst completion.

Behaviour:
- Array: 2^DEPTH_LOG2 words, word index = addr[DEPTH_LOG2+1:2]. Array contents are not cleared by reset.
- Reset (rst_n=0 at edge):
  - Outputs: rom_data_o=NOP_WORD; rom_valid_o, rom_misalign_o, load_ready_o, load_busy_o, load_done_o all 0.
  - FSM returns to IDLE.
  - Reset mid-burst abandons the burst; words already written stay written; no done pulse.
- FSM states: IDLE and LOAD.
  - IDLE + load_start_i:
    - If load_len_i!=0: go to LOAD; ptr=load_base_i[DEPTH_LOG2+1:2]; remaining=load_len_i.
    - If load_len_i==0: stay IDLE; load_done_o=1 next cycle.
  - LOAD:
    - load_ready_o=1 and load_busy_o=1 (both registered, asserted the cycle after start).
    - Each edge with load_valid_i=1 writes mem[ptr]=load_data_i, ptr++ (wraps modulo 2^DEPTH_LOG2), remaining--.
    - The write that makes remaining 0 returns FSM to IDLE. load_ready_o and load_busy_o drop and load_done_o=1 for exactly one cycle.
    - load_start_i is ignored while in LOAD.
    - load_len_i > 2^DEPTH_LOG2 wraps and overwrites earlier words; this is legal.
- Fetch: registered, 1-cycle latency, evaluated on every edge with FSM in IDLE.
  - Priority order: reset > stall > ce.
  - rom_stall_i=1: rom_data_o, rom_valid_o, rom_misalign_o hold.
  - rom_ce_i=0: data=NOP_WORD, valid=0, misalign=0.
  - rom_ce_i=1 and rom_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2]!=0: data=NOP_WORD, valid=1, misalign per addr[1:0].
  - rom_ce_i=1, in range: data=mem[index], valid=1, misalign=(addr[1:0]!=0). Data is still returned from the truncated index.
- Fetch during LOAD:
  - Edges in LOAD, and the edge that leaves LOAD, force data=NOP_WORD, valid=0 regardless of stall.
  - First real fetch result appears the cycle after load_done_o.
- Read/write collision is impossible, because fetch and load are mutually exclusive by state.

Optional Feature:
- Macro: INST_MEM_PARITY_EN.
- With macro:
  - Each word stores an extra even-parity bit computed on write.
  - Adds input load_par_inv_i (1), which inverts the stored parity bit on write for error injection.
  - Adds output rom_par_err_o (1), registered alongside rom_data_o; it is 1 when a valid in-range fetch reads a word whose parity mismatches, and holds under stall. Reset value 0.
- Without macro: no parity storage, no extra ports, behaviour otherwise identical.

Test Plan:
- Reset then ce=1, addr=0 → rom_data_o=NOP_WORD, valid=0 during reset; valid=1 one cycle after release.
- Load base=0, len=3, data 34018000/00010c00/34210010 with a valid gap cycle → load_done_o pulses once, after the 3rd write. Then fetch 0,4,8 → same words 1 cycle later, valid=1.
- Fetch addr=0x4 then hold rom_stall_i=1 for 3 cycles while addr changes to 0x8 → rom_data_o stays 00010c00.
- Fetch addr=0x6 → misalign=1, data=00010c00. Fetch addr=0x1000 (DEPTH_LOG2=10) → data=NOP_WORD, valid=1.
- Load base=0xFFC, len=2 → words land at index 1023 and 0 (wrap). Assert rst_n=0 during a len=4 burst after 2 writes → FSM IDLE, no done pulse, 2 words kept.
- (INST_MEM_PARITY_EN) Load with load_par_inv_i=1 at addr 0x10, fetch 0x10 → rom_par_err_o=1. Fetch a clean word → rom_par_err_o=0.
